// File: rtl/regop_scheduler.sv
// Round-robin scheduler sharing one register-file datapath between requesters A and B.
// Optional per-requester accept counters (ops_a/ops_b) when REGOP_SCHED_STATS_EN is defined.
module regop_scheduler #(
  parameter int EXEC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a_valid,
  input  logic [15:0] req_a_op,
  output logic        req_a_ready,
  input  logic        req_b_valid,
  input  logic [15:0] req_b_op,
  output logic        req_b_ready,
  output logic        dp_en,
  output logic [3:0]  dp_mode,
  output logic [3:0]  dp_rx,
  output logic [3:0]  dp_ry,
  output logic [3:0]  dp_rz,
  input  logic        dp_cy,
  output logic        resp_valid,
  output logic        resp_id,
  output logic        resp_cy,
  output logic        resp_err,
  input  logic        resp_ready,
  output logic        busy
`ifdef REGOP_SCHED_STATS_EN
  ,
  output logic [15:0] ops_a,
  output logic [15:0] ops_b
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] MODE_ADD = 4'b0001;
  localparam logic [3:0] MODE_AND = 4'b0010;

  logic [1:0]  state;
  logic        last;      // id served most recently; 1 = B
  logic [15:0] op_q;
  logic        id_q;
  logic        err_q;
  logic        cy_q;
  logic [3:0]  cnt;

  logic        grant_a;
  logic        grant_b;
  logic        accept;
  logic        acc_id;
  logic [15:0] acc_op;
  logic        acc_legal;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a_valid && req_b_valid) begin
      grant_a = last;
      grant_b = ~last;
    end else begin
      grant_a = req_a_valid;
      grant_b = req_b_valid;
    end
  end

  assign req_a_ready = ~rst & (state == S_IDLE) & grant_a;
  assign req_b_ready = ~rst & (state == S_IDLE) & grant_b;

  assign accept    = req_a_ready | req_b_ready;
  assign acc_id    = req_b_ready;
  assign acc_op    = req_b_ready ? req_b_op : req_a_op;
  assign acc_legal = (acc_op[15:12] == MODE_ADD) || (acc_op[15:12] == MODE_AND);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= 1'b1;
      op_q  <= '0;
      id_q  <= 1'b0;
      err_q <= 1'b0;
      cy_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= acc_op;
            id_q <= acc_id;
            last <= acc_id;
            cy_q <= 1'b0;
            if (acc_legal) begin
              err_q <= 1'b0;
              state <= S_ISSUE;
            end else begin
              // Illegal ops skip the datapath but spend one WAIT cycle, so the
              // response still appears one edge after the accept edge.
              err_q <= 1'b1;
              cnt   <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= 4'(EXEC_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            cy_q  <= err_q ? 1'b0 : dp_cy;
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath lines are decoded from state so they read as hold/zero outside ISSUE.
  assign dp_en   = (state == S_ISSUE);
  assign dp_mode = dp_en ? op_q[15:12] : 4'd0;
  assign dp_rx   = dp_en ? op_q[11:8]  : 4'd0;
  assign dp_ry   = dp_en ? op_q[7:4]   : 4'd0;
  assign dp_rz   = dp_en ? op_q[3:0]   : 4'd0;

  assign resp_valid = (state == S_RESP);
  assign resp_id    = resp_valid & id_q;
  assign resp_cy    = resp_valid & cy_q;
  assign resp_err   = resp_valid & err_q;
  assign busy       = (state != S_IDLE);

`ifdef REGOP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_a <= '0;
      ops_b <= '0;
    end else begin
      if (req_a_ready) ops_a <= ops_a + 16'd1;
      if (req_b_ready) ops_b <= ops_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regop_scheduler.sv
// Self-checking bench for regop_scheduler: vector table plus hand sequences,
// with a response scoreboard and a latency-accurate datapath carry model.
module tb_regop_scheduler;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        req_a_valid;
  logic [15:0] req_a_op;
  logic        req_a_ready;
  logic        req_b_valid;
  logic [15:0] req_b_op;
  logic        req_b_ready;
  logic        dp_en;
  logic [3:0]  dp_mode;
  logic [3:0]  dp_rx;
  logic [3:0]  dp_ry;
  logic [3:0]  dp_rz;
  logic        dp_cy;
  logic        resp_valid;
  logic        resp_id;
  logic        resp_cy;
  logic        resp_err;
  logic        resp_ready;
  logic        busy;
`ifdef REGOP_SCHED_STATS_EN
  logic [15:0] ops_a;
  logic [15:0] ops_b;
`endif

  regop_scheduler #(.EXEC_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a_valid (req_a_valid),
    .req_a_op    (req_a_op),
    .req_a_ready (req_a_ready),
    .req_b_valid (req_b_valid),
    .req_b_op    (req_b_op),
    .req_b_ready (req_b_ready),
    .dp_en       (dp_en),
    .dp_mode     (dp_mode),
    .dp_rx       (dp_rx),
    .dp_ry       (dp_ry),
    .dp_rz       (dp_rz),
    .dp_cy       (dp_cy),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_cy     (resp_cy),
    .resp_err    (resp_err),
    .resp_ready  (resp_ready),
    .busy        (busy)
`ifdef REGOP_SCHED_STATS_EN
    ,
    .ops_a       (ops_a),
    .ops_b       (ops_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic id;
    logic cy;
    logic err;
    int   rise;
  } exp_t;

  typedef struct {
    logic        va;
    logic [15:0] opa;
    logic        vb;
    logic [15:0] opb;
    logic        first;
  } vec_t;

  exp_t        resp_q[$];
  logic [15:0] issue_q[$];
  logic        acc_ids[$];

  function automatic logic legal_mode(input logic [3:0] m);
    return (m == 4'd1) || (m == 4'd2);
  endfunction

  // Scoreboard push at the accept edge (cyc+1 is that edge's number).
  task automatic push_exp(input logic id, input logic [15:0] op);
    exp_t e;
    logic lg;
    lg     = legal_mode(op[15:12]);
    e.id   = id;
    e.err  = ~lg;
    e.cy   = lg ? ^op : 1'b0;
    e.rise = lg ? cyc + 2 + LAT : cyc + 2;
    resp_q.push_back(e);
    if (lg) issue_q.push_back(op);
    acc_ids.push_back(id);
  endtask

  // Monitor and datapath model, sampled on the falling edge.
  logic prev_rv   = 1'b0;
  int   issue_cyc = -100;
  logic issue_cy  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rv   = 1'b0;
      issue_cyc = -100;
      dp_cy     = 1'b0;
    end else begin
      if (req_a_valid && req_a_ready) push_exp(1'b0, req_a_op);
      if (req_b_valid && req_b_ready) push_exp(1'b1, req_b_op);
      if (dp_en) begin
        if (issue_q.size() == 0) begin
          check("unexpected dp_en", {31'd0, dp_en}, 32'd0);
        end else begin
          logic [15:0] op;
          op = issue_q.pop_front();
          check("dp fields", {16'd0, dp_mode, dp_rx, dp_ry, dp_rz}, {16'd0, op});
          issue_cyc = cyc;
          issue_cy  = ^op;
        end
      end else begin
        check("dp_mode hold", {28'd0, dp_mode}, 32'd0);
      end
      if (resp_valid && !prev_rv) begin
        if (resp_q.size() == 0) check("unexpected resp_valid", {31'd0, resp_valid}, 32'd0);
        else check("resp latency", cyc, resp_q[0].rise);
      end
      if (resp_valid && resp_ready && resp_q.size() > 0) begin
        exp_t e;
        e = resp_q.pop_front();
        check("resp id/cy/err", {29'd0, resp_id, resp_cy, resp_err}, {29'd0, e.id, e.cy, e.err});
      end
      prev_rv = resp_valid;
      // Carry is only correct in the cycle the datapath promises it.
      dp_cy = (cyc == issue_cyc + LAT) ? issue_cy : ~issue_cy;
    end
  end

  task automatic check_zero(input string name);
    check(name, {8'd0, req_a_ready, req_b_ready, dp_en, dp_mode, dp_rx, dp_ry, dp_rz,
                 resp_valid, resp_id, resp_cy, resp_err, busy}, 32'd0);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (resp_q.size() == 0 && issue_q.size() == 0 && !busy) break;
    end
    check("drain pending", resp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int start;
    int seen;
    start = acc_ids.size();
    seen  = start;
    req_a_valid = v.va;
    req_a_op    = v.opa;
    req_b_valid = v.vb;
    req_b_op    = v.opb;
    for (int t = 0; t < 200 && (req_a_valid || req_b_valid); t++) begin
      @(posedge clk);
      #1;
      while (seen < acc_ids.size()) begin
        if (acc_ids[seen] == 1'b0) req_a_valid = 1'b0;
        else req_b_valid = 1'b0;
        seen++;
      end
    end
    check($sformatf("vec%0d accept timeout", idx), {30'd0, req_a_valid, req_b_valid}, 32'd0);
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    if (acc_ids.size() > start)
      check($sformatf("vec%0d first grant", idx), {31'd0, acc_ids[start]}, {31'd0, v.first});
    else
      check($sformatf("vec%0d accepts", idx), acc_ids.size() - start, 1);
    wait_drain();
  endtask

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    int n;
    logic a_done;

    vecs[0] = '{1'b1, 16'h1123, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h1abc, 1'b1};
    vecs[2] = '{1'b1, 16'h2111, 1'b1, 16'h2222, 1'b0};
    vecs[3] = '{1'b1, 16'h2345, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 16'h1777, 1'b1, 16'h1888, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'h7456, 1'b1};
    vecs[6] = '{1'b1, 16'h0123, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 16'h3fff, 1'b1, 16'hf000, 1'b1};
    vecs[8] = '{1'b1, 16'h1ffe, 1'b0, 16'h0000, 1'b0};

    rst         = 1'b1;
    req_a_valid = 1'b1;
    req_a_op    = 16'h2123;
    req_b_valid = 1'b1;
    req_b_op    = 16'h2456;
    resp_ready  = 1'b1;
    dp_cy       = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("reset outputs");

    // Both requesters valid out of reset: expect A, B, A.
    @(posedge clk);
    #1 rst = 1'b0;
    base   = acc_ids.size();
    seen   = base;
    n      = 0;
    a_done = 1'b0;
    for (int t = 0; t < 200 && n < 3; t++) begin
      @(posedge clk);
      #1;
      while (seen < acc_ids.size()) begin
        if (acc_ids[seen] == 1'b0) begin
          if (!a_done) begin
            req_a_op = 16'h2abc;
            a_done   = 1'b1;
          end else begin
            req_a_valid = 1'b0;
          end
        end else begin
          req_b_valid = 1'b0;
        end
        seen++;
        n++;
      end
    end
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    if (acc_ids.size() >= base + 3)
      check("grant order A,B,A", {29'd0, acc_ids[base], acc_ids[base+1], acc_ids[base+2]}, 32'b010);
    else
      check("grant order count", acc_ids.size() - base, 3);
    wait_drain();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Response back-pressure with B waiting.
    resp_ready  = 1'b0;
    req_a_valid = 1'b1;
    req_a_op    = 16'h1123;
    base        = acc_ids.size();
    for (int t = 0; t < 50 && acc_ids.size() == base; t++) @(posedge clk);
    #1 req_a_valid = 1'b0;
    for (int t = 0; t < 50 && !resp_valid; t++) @(posedge clk);
    #1 req_b_valid = 1'b1;
    req_b_op = 16'h2456;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d resp", i), {27'd0, resp_valid, resp_id, resp_cy, resp_err, busy},
            {27'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
      check($sformatf("stall%0d readies", i), {30'd0, req_a_ready, req_b_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after release busy/ready_b", {30'd0, busy, req_b_ready}, {30'd0, 1'b0, 1'b1});
    base = acc_ids.size();
    for (int t = 0; t < 50 && acc_ids.size() == base; t++) @(posedge clk);
    #1 req_b_valid = 1'b0;
    wait_drain();

    // Asynchronous reset in the middle of WAIT.
    req_a_valid = 1'b1;
    req_a_op    = 16'h1123;
    base        = acc_ids.size();
    for (int t = 0; t < 50 && acc_ids.size() == base; t++) @(posedge clk);
    #1 req_a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("in WAIT", {30'd0, busy, dp_en}, {30'd0, 1'b1, 1'b0});
    rst = 1'b1;
    resp_q.delete();
    issue_q.delete();
    #1;
    check_zero("async reset outputs");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_vec('{1'b1, 16'h2aaa, 1'b1, 16'h2bbb, 1'b0}, 100);

`ifdef REGOP_SCHED_STATS_EN
    run_vec('{1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0}, 101);
    run_vec('{1'b1, 16'h2222, 1'b1, 16'h7000, 1'b1}, 102);
    check("ops_a", {16'd0, ops_a}, 32'd3);
    check("ops_b", {16'd0, ops_b}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
